uart_prog_loader: RTL and testbench

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_prog_loader_pkg.sv | 16 +
 rtl/uart_prog_loader_if.sv | 13 +
 rtl/uart_prog_loader_byte_packer.sv | 41 ++++
 rtl/uart_prog_loader.sv | 184 ++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: loader states and
// checksum width.
package prog_loader_pkg;

    localparam int CHECKSUM_WIDTH = 8;

    typedef enum logic [2:0] {
        S_WAIT_COUNT = 3'd0,
        S_WAIT_BYTE  = 3'd1,
        S_WRITE      = 3'd2,
        S_WAIT_CSUM  = 3'd3,
        S_DONE       = 3'd4,
        S_ERROR      = 3'd5
    } state_e;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Program-memory write port: request, address, data and ready handshake.
interface uart_prog_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;

    modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ready);
    modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/uart_prog_loader_byte_packer.sv
// Packs a stream of bytes into a word; slot order selected by BIG_ENDIAN.
// The word register only changes on accepted bytes, so it stays stable
// while the loader waits on the memory.
module byte_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [BYTE_WIDTH-1:0] in_byte,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  last
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    logic [IDX_W-1:0] idx;
    int               slot;

    // Byte slot for the current index, mirrored for big-endian words
    always_comb begin
        slot = (BIG_ENDIAN != 0) ? (NB - 1 - int'(idx)) : int'(idx);
        last = (idx == IDX_W'(NB - 1));
    end

    // Drop the byte into its slot and advance the index, wrapping per word
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            word <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (in_valid) begin
            word[slot*BYTE_WIDTH +: BYTE_WIDTH] <= in_byte;
            idx <= last ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: header word count, payload packed into words and
// written to program memory, trailing checksum byte, inter-byte timeout.
//
// state        | meaning
// WAIT_COUNT   | collecting the little-endian word-count header
// WAIT_BYTE    | assembling payload bytes into the next word
// WRITE        | write request held until mem_ready
// WAIT_CSUM    | waiting for the checksum byte
// DONE         | program loaded, prog_rdy high
// ERROR        | checksum, timeout or overrun fault, waiting for start
module uart_prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int COUNT_BYTES    = 2,
    parameter int BIG_ENDIAN     = 0,
    parameter int ADDR_STEP      = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [BYTE_WIDTH-1:0]    rx_data,
    input  logic                     start,
    uart_prog_loader_if.master       mem,
    output logic                     prog_rdy,
    output logic                     err_checksum,
    output logic                     err_timeout,
    output logic                     err_overrun,
    output logic [8*COUNT_BYTES-1:0] n_instructions,
    output logic [2:0]               state
);
    localparam int CNT_W  = 8 * COUNT_BYTES;
    localparam int CIDX_W = (COUNT_BYTES > 1) ? $clog2(COUNT_BYTES) : 1;
    localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

    state_e                    state_q;
    logic [CIDX_W-1:0]         cnt_idx;
    logic [CNT_W-1:0]          n_instr, n_next, word_cnt;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic                      we_q;
    logic [CHECKSUM_WIDTH-1:0] csum_q, csum_next;
    logic                      buf_valid;
    logic [BYTE_WIDTH-1:0]     buf_data;
    logic [TMR_W-1:0]          timer;
    logic                      byte_take, timed, pk_valid, pk_clr, pk_last;
    logic [BYTE_WIDTH-1:0]     byte_val;
    logic [DATA_WIDTH-1:0]     pk_word;

    // Byte source selection: a buffered byte always goes ahead of the live one
    always_comb begin
        byte_take = ((state_q == S_WAIT_COUNT) || (state_q == S_WAIT_BYTE) ||
                     (state_q == S_WAIT_CSUM)) && (buf_valid || rx_valid);
        byte_val  = buf_valid ? buf_data : rx_data;
        csum_next = csum_q + byte_val[CHECKSUM_WIDTH-1:0];
        n_next    = n_instr;
        n_next[8*int'(cnt_idx) +: 8] = byte_val[7:0];
        timed     = (state_q == S_WAIT_BYTE) || (state_q == S_WAIT_CSUM) ||
                    ((state_q == S_WAIT_COUNT) && (cnt_idx != '0));
        pk_valid  = byte_take && (state_q == S_WAIT_BYTE);
        pk_clr    = start && ((state_q == S_DONE) || (state_q == S_ERROR));
    end

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (pk_clr),
        .in_valid (pk_valid),
        .in_byte  (byte_val),
        .word     (pk_word),
        .last     (pk_last)
    );

    // Sequencer: header, payload, stalled writes, checksum, timeout and re-arm
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT_COUNT;
            cnt_idx      <= '0;
            n_instr      <= '0;
            word_cnt     <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            csum_q       <= '0;
            buf_valid    <= 1'b0;
            buf_data     <= '0;
            timer        <= '0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            if (byte_take) begin
                timer <= '0;
                if (buf_valid && !rx_valid) buf_valid <= 1'b0;
                if (buf_valid && rx_valid)  buf_data  <= rx_data;
            end else if (timed && (TIMEOUT_CYCLES > 0)) begin
                if (timer == TMR_LAST) begin
                    err_timeout <= 1'b1;
                    state_q     <= S_ERROR;
                end else begin
                    timer <= timer + 1'b1;
                end
            end

            case (state_q)
                S_WAIT_COUNT: if (byte_take) begin
                    n_instr <= n_next;
                    csum_q  <= csum_next;
                    if (cnt_idx == CIDX_W'(COUNT_BYTES - 1)) begin
                        cnt_idx <= '0;
                        state_q <= (n_next == '0) ? S_WAIT_CSUM : S_WAIT_BYTE;
                    end else begin
                        cnt_idx <= cnt_idx + 1'b1;
                    end
                end
                S_WAIT_BYTE: if (byte_take) begin
                    csum_q <= csum_next;
                    if (pk_last) begin
                        we_q    <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (rx_valid && buf_valid) begin
                        err_overrun <= 1'b1;
                        we_q        <= 1'b0;
                        state_q     <= S_ERROR;
                    end else begin
                        if (rx_valid) begin
                            buf_valid <= 1'b1;
                            buf_data  <= rx_data;
                        end
                        if (mem.mem_ready) begin
                            we_q     <= 1'b0;
                            word_cnt <= word_cnt + 1'b1;
                            if (word_cnt + 1'b1 == n_instr) begin
                                state_q <= S_WAIT_CSUM;
                            end else begin
                                addr_q  <= addr_q + ADDR_WIDTH'(ADDR_STEP);
                                state_q <= S_WAIT_BYTE;
                            end
                        end
                    end
                end
                S_WAIT_CSUM: if (byte_take) begin
                    csum_q <= csum_next;
                    if (csum_next == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        err_checksum <= 1'b1;
                        state_q      <= S_ERROR;
                    end
                end
                S_DONE, S_ERROR: if (start) begin
                    state_q      <= S_WAIT_COUNT;
                    cnt_idx      <= '0;
                    word_cnt     <= '0;
                    addr_q       <= '0;
                    csum_q       <= '0;
                    buf_valid    <= 1'b0;
                    buf_data     <= '0;
                    timer        <= '0;
                    err_checksum <= 1'b0;
                    err_timeout  <= 1'b0;
                    err_overrun  <= 1'b0;
                end
                default: state_q <= S_WAIT_COUNT;
            endcase
        end
    end

    assign mem.mem_we      = we_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_wdata   = pk_word;
    assign prog_rdy        = (state_q == S_DONE);
    assign n_instructions  = n_instr;
    assign state           = state_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: a little-endian and a big-endian instance see
// the same byte stream; writes are compared against a packet-level model.
module tb_uart_prog_loader;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int TO = 50;

    localparam logic [2:0] ST_WAIT_COUNT = 3'd0;
    localparam logic [2:0] ST_WAIT_BYTE  = 3'd1;
    localparam logic [2:0] ST_WRITE      = 3'd2;
    localparam logic [2:0] ST_DONE       = 3'd4;
    localparam logic [2:0] ST_ERROR      = 3'd5;

    typedef logic [7:0] bq_t[$];
    typedef logic [2*(1+AW+DW)-1:0] wr_t;

    logic clk = 1'b0;
    logic rst, rx_valid, start;
    logic [7:0] rx_data;

    logic        prog_rdy_le, err_checksum_le, err_timeout_le, err_overrun_le;
    logic        prog_rdy_be, err_checksum_be, err_timeout_be, err_overrun_be;
    logic [15:0] n_le, n_be;
    logic [2:0]  state_le, state_be;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t got[$];
    wr_t exp_q[$];

    always #5 clk = ~clk;

    uart_prog_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_le ();
    uart_prog_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_be ();

    uart_prog_loader #(.BIG_ENDIAN(0), .TIMEOUT_CYCLES(TO)) dut_le (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .start(start),
        .mem(mem_le), .prog_rdy(prog_rdy_le), .err_checksum(err_checksum_le),
        .err_timeout(err_timeout_le), .err_overrun(err_overrun_le),
        .n_instructions(n_le), .state(state_le));

    uart_prog_loader #(.BIG_ENDIAN(1), .TIMEOUT_CYCLES(TO)) dut_be (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .start(start),
        .mem(mem_be), .prog_rdy(prog_rdy_be), .err_checksum(err_checksum_be),
        .err_timeout(err_timeout_be), .err_overrun(err_overrun_be),
        .n_instructions(n_be), .state(state_be));

    wire [6:0]  st_le = {state_le, prog_rdy_le, err_checksum_le, err_timeout_le, err_overrun_le};
    wire [6:0]  st_be = {state_be, prog_rdy_be, err_checksum_be, err_timeout_be, err_overrun_be};
    wire [13:0] st    = {st_le, st_be};
    wire wr_t   bus   = {mem_le.mem_we, mem_le.mem_addr, mem_le.mem_wdata,
                         mem_be.mem_we, mem_be.mem_addr, mem_be.mem_wdata};

    // Record every completed write (request high while memory is ready)
    always @(negedge clk) begin
        if ((mem_le.mem_we && mem_le.mem_ready) || (mem_be.mem_we && mem_be.mem_ready))
            got.push_back({mem_le.mem_we && mem_le.mem_ready, mem_le.mem_addr, mem_le.mem_wdata,
                           mem_be.mem_we && mem_be.mem_ready, mem_be.mem_addr, mem_be.mem_wdata});
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
        got.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
        got.delete();
    endtask

    task automatic set_ready(input logic r);
        mem_le.mem_ready = r;
        mem_be.mem_ready = r;
    endtask

    // Sends the first n bytes of q (all if n < 0) with 1..max_gap idle cycles between
    task automatic send_packet(input bq_t q, input int n, input int max_gap);
        int lim;
        lim = (n < 0) ? q.size() : n;
        for (int i = 0; i < lim; i++) begin
            repeat ($urandom_range(1, max_gap)) step();
            rx_valid = 1'b1; rx_data = q[i];
            step();
            rx_valid = 1'b0;
        end
    endtask

    // Packet model: count header, words, addresses and checksum verdict from the raw bytes
    task automatic model(input bq_t q, output bit good, output int n);
        int sum;
        logic [DW-1:0] le, be;
        logic [AW-1:0] a;
        exp_q.delete();
        n = int'(q[0]) + 256 * int'(q[1]);
        sum = 0;
        foreach (q[i]) sum += int'(q[i]);
        good = ((sum % 256) == 0);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                le[8*k +: 8]     = q[2 + 4*w + k];
                be[8*(3-k) +: 8] = q[2 + 4*w + k];
            end
            a = AW'((4 * w) % 1024);
            exp_q.push_back({1'b1, a, le, 1'b1, a, be});
        end
    endtask

    task automatic make_packet(input int n, input bit corrupt, output bq_t q);
        int sum;
        logic [7:0] cs;
        q = {};
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
        sum = 0;
        foreach (q[i]) sum += int'(q[i]);
        cs = 8'(256 - (sum % 256));
        if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
        q.push_back(cs);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (st !== 14'd0) begin n_fail++; $display("FAIL reset_status: got %h want %h", st, 14'd0); end
        n_tests++;
        if ({n_le, n_be} !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %h want 0", {n_le, n_be}); end
        n_tests++;
        if (bus !== '0) begin n_fail++; $display("FAIL reset_mem_bus: got %h want 0", bus); end
    endtask

    // Two-instruction program; count is little-endian, checksum zeroes the byte sum
    task automatic test_basic();
        bq_t q;
        bit good;
        int n;
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h48};
        do_reset();
        model(q, good, n);
        send_packet(q, -1, 3);
        step();
        n_tests++;
        if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_nwrites: got %0d want %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_write%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
        n_tests++;
        if (st !== {ST_DONE, 4'b1000, ST_DONE, 4'b1000}) begin n_fail++; $display("FAIL basic_status: got %h want %h", st, {ST_DONE, 4'b1000, ST_DONE, 4'b1000}); end
        n_tests++;
        if ({n_le, n_be} !== {16'(n), 16'(n)}) begin n_fail++; $display("FAIL basic_count: got %h want %h", {n_le, n_be}, {16'(n), 16'(n)}); end
    endtask

    task automatic test_bad_csum();
        bq_t q;
        bit good;
        int n;
        q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        pulse_start();
        model(q, good, n);
        send_packet(q, -1, 3);
        step();
        n_tests++;
        if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL badcs_nwrites: got %0d want %0d", got.size(), exp_q.size()); end
        n_tests++;
        if (st !== {ST_ERROR, 4'b0100, ST_ERROR, 4'b0100}) begin n_fail++; $display("FAIL badcs_status: got %h want %h", st, {ST_ERROR, 4'b0100, ST_ERROR, 4'b0100}); end
    endtask

    task automatic test_empty();
        bq_t q;
        q = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        n_tests++;
        if (st !== 14'd0) begin n_fail++; $display("FAIL rearm_status: got %h want 0", st); end
        send_packet(q, -1, 3);
        step();
        n_tests++;
        if (got.size() != 0) begin n_fail++; $display("FAIL empty_nwrites: got %0d want 0", got.size()); end
        n_tests++;
        if (st !== {ST_DONE, 4'b1000, ST_DONE, 4'b1000}) begin n_fail++; $display("FAIL empty_status: got %h want %h", st, {ST_DONE, 4'b1000, ST_DONE, 4'b1000}); end
    endtask

    task automatic test_stall();
        bq_t q;
        bit good;
        int n;
        make_packet(1, 1'b0, q);
        do_reset();
        model(q, good, n);
        set_ready(1'b0);
        send_packet(q, 6, 2);
        for (int i = 0; i < 20; i++) begin
            rx_valid = (i == 5); rx_data = q[6];
            step();
            rx_valid = 1'b0;
            n_tests++;
            if (bus !== exp_q[0]) begin n_fail++; $display("FAIL stall_hold c%0d: got %h want %h", i, bus, exp_q[0]); end
        end
        n_tests++;
        if (st !== {ST_WRITE, 4'b0000, ST_WRITE, 4'b0000}) begin n_fail++; $display("FAIL stall_status: got %h want %h", st, {ST_WRITE, 4'b0000, ST_WRITE, 4'b0000}); end
        set_ready(1'b1);
        repeat (3) step();
        n_tests++;
        if (got.size() != 1) begin n_fail++; $display("FAIL stall_nwrites: got %0d want 1", got.size()); end
        else begin
            n_tests++;
            if (got[0] !== exp_q[0]) begin n_fail++; $display("FAIL stall_write: got %h want %h", got[0], exp_q[0]); end
        end
        n_tests++;
        if (st !== {ST_DONE, 4'b1000, ST_DONE, 4'b1000}) begin n_fail++; $display("FAIL stall_done: got %h want %h", st, {ST_DONE, 4'b1000, ST_DONE, 4'b1000}); end

        // Second byte during the stall overflows the one-entry buffer
        do_reset();
        set_ready(1'b0);
        send_packet(q, 6, 2);
        for (int i = 0; i < 10; i++) begin
            rx_valid = (i == 2) || (i == 6); rx_data = q[6];
            step();
            rx_valid = 1'b0;
        end
        n_tests++;
        if (st !== {ST_ERROR, 4'b0001, ST_ERROR, 4'b0001}) begin n_fail++; $display("FAIL overrun_status: got %h want %h", st, {ST_ERROR, 4'b0001, ST_ERROR, 4'b0001}); end
        n_tests++;
        if ({mem_le.mem_we, mem_be.mem_we} !== 2'b00) begin n_fail++; $display("FAIL overrun_we: got %b want 00", {mem_le.mem_we, mem_be.mem_we}); end
        set_ready(1'b1);
        repeat (3) step();
        n_tests++;
        if (got.size() != 0) begin n_fail++; $display("FAIL overrun_nwrites: got %0d want 0", got.size()); end
    endtask

    task automatic test_timeout();
        bq_t q, p;
        bit good;
        int n;
        q = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        do_reset();
        send_packet(q, -1, 3);
        repeat (TO - 1) step();
        n_tests++;
        if (st !== {ST_WAIT_BYTE, 4'b0000, ST_WAIT_BYTE, 4'b0000}) begin n_fail++; $display("FAIL timeout_early: got %h want %h", st, {ST_WAIT_BYTE, 4'b0000, ST_WAIT_BYTE, 4'b0000}); end
        step();
        n_tests++;
        if (st !== {ST_ERROR, 4'b0010, ST_ERROR, 4'b0010}) begin n_fail++; $display("FAIL timeout_hit: got %h want %h", st, {ST_ERROR, 4'b0010, ST_ERROR, 4'b0010}); end
        pulse_start();
        n_tests++;
        if (st !== 14'd0) begin n_fail++; $display("FAIL timeout_rearm: got %h want 0", st); end
        make_packet(2, 1'b0, p);
        model(p, good, n);
        send_packet(p, -1, 4);
        step();
        n_tests++;
        if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL timeout_nwrites: got %0d want %0d", got.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got.size()) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL timeout_write%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_word();
        bq_t q, p;
        bit good;
        int n;
        q = '{8'h02, 8'h00, 8'h5A, 8'hC3};
        do_reset();
        send_packet(q, -1, 3);
        rst = 1'b1; step(); rst = 1'b0;
        n_tests++;
        if (st !== 14'd0) begin n_fail++; $display("FAIL midrst_status: got %h want 0", st); end
        n_tests++;
        if ({n_le, n_be} !== 32'd0) begin n_fail++; $display("FAIL midrst_count: got %h want 0", {n_le, n_be}); end
        n_tests++;
        if (bus !== '0) begin n_fail++; $display("FAIL midrst_bus: got %h want 0", bus); end
        got.delete();
        p = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEB};
        model(p, good, n);
        send_packet(p, -1, 3);
        step();
        n_tests++;
        if (got.size() != 1) begin n_fail++; $display("FAIL be_nwrites: got %0d want 1", got.size()); end
        else begin
            n_tests++;
            if (got[0] !== exp_q[0]) begin n_fail++; $display("FAIL be_write: got %h want %h", got[0], exp_q[0]); end
            n_tests++;
            if (got[0][31:0] !== 32'h12345678) begin n_fail++; $display("FAIL be_word: got %h want 12345678", got[0][31:0]); end
        end
        n_tests++;
        if (st !== {ST_DONE, 4'b1000, ST_DONE, 4'b1000}) begin n_fail++; $display("FAIL be_status: got %h want %h", st, {ST_DONE, 4'b1000, ST_DONE, 4'b1000}); end
    endtask

    task automatic test_random();
        bq_t q;
        bit good, corrupt;
        int n;
        logic [6:0] es;
        do_reset();
        for (int it = 0; it < 12; it++) begin
            corrupt = ($urandom_range(0, 3) == 0);
            make_packet($urandom_range(0, 5), corrupt, q);
            model(q, good, n);
            send_packet(q, -1, 4);
            step();
            es = good ? {ST_DONE, 4'b1000} : {ST_ERROR, 4'b0100};
            n_tests++;
            if (st !== {es, es}) begin n_fail++; $display("FAIL rand%0d_status: got %h want %h", it, st, {es, es}); end
            n_tests++;
            if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_nwrites: got %0d want %0d", it, got.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got.size()) begin
                n_tests++;
                if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_write%0d: got %h want %h", it, i, got[i], exp_q[i]); end
            end
            pulse_start();
        end
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; start = 1'b0;
        set_ready(1'b1);
        step();
        test_reset();
        test_basic();
        test_bad_csum();
        test_empty();
        test_stall();
        test_timeout();
        test_reset_mid_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
